// File: rtl/lab_ass_2_pkg.sv
// Shared types and constants for the lab_ass_2 four-input truth-table evaluator.
package lab_ass_2_pkg;

    localparam logic [15:0] DEFAULT_TT = 16'hF222;

    typedef logic [3:0]  idx_t;
    typedef logic [15:0] tt_t;

endpackage

// File: rtl/lab_ass_2_sat_cnt.sv
// Generic saturating up-counter with asynchronous active-high reset.
module lab_ass_2_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Stop at all-ones so the count never wraps back to zero.
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/lab_ass_2.sv
// Four-input Boolean function evaluator: table lookup, registered result, true-result counter.
// Define LAB_ASS_2_TT_PROG_EN to make the truth table runtime-writable via tt_we/tt_wdata.
module lab_ass_2
    import lab_ass_2_pkg::*;
#(
    parameter logic [15:0] TRUTH_TABLE = DEFAULT_TT,
    parameter int          CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
`ifdef LAB_ASS_2_TT_PROG_EN
    input  logic             tt_we,
    input  logic [15:0]      tt_wdata,
`endif
    output logic             f_comb,
    output logic             f,
    output logic             f_valid,
    output logic [CNT_W-1:0] true_cnt
);

    tt_t  activeTable;
    idx_t lookupIdx;
    logic result_q;
    logic result_d;
    logic resultValid_q;
    logic resultValid_d;

`ifdef LAB_ASS_2_TT_PROG_EN
    tt_t table_q;

    // A write lands at the edge, so a same-cycle evaluation still sees the old table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            table_q <= TRUTH_TABLE;
        end else if (tt_we) begin
            table_q <= tt_wdata;
        end
    end

    assign activeTable = table_q;
`else
    assign activeTable = TRUTH_TABLE;
`endif

    assign lookupIdx = {a, b, c, d};
    assign f_comb    = activeTable[lookupIdx];

    always_comb begin
        result_d      = result_q;
        resultValid_d = in_valid;
        if (in_valid) begin
            result_d = f_comb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q      <= 1'b0;
            resultValid_q <= 1'b0;
        end else begin
            result_q      <= result_d;
            resultValid_q <= resultValid_d;
        end
    end

    assign f       = result_q;
    assign f_valid = resultValid_q;

    lab_ass_2_sat_cnt #(
        .WIDTH (CNT_W)
    ) u_trueCnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (in_valid & f_comb),
        .count_o (true_cnt)
    );

endmodule

// File: tb/tb_lab_ass_2.sv
// Scoreboard bench for lab_ass_2: default-width and 2-bit-counter instances share stimulus.
// Exercises the LAB_ASS_2_TT_PROG_EN table-write path when that macro is defined.
module tb_lab_ass_2;

    localparam logic [15:0] SPEC_TT = 16'hF222;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid;
    logic       a, b, c, d;
    logic       fComb, f, fValid;
    logic       fComb2, f2, fValid2;
    logic [7:0] trueCnt;
    logic [1:0] trueCnt2;
`ifdef LAB_ASS_2_TT_PROG_EN
    logic        ttWe;
    logic [15:0] ttWdata;
`endif

    typedef struct packed {
        logic       f;
        logic       fv;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] tbl;
    logic        mF;
    logic [7:0]  mCnt;
    logic [1:0]  mCnt2;
    logic [1:0]  satSeq [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    always #5 clk = ~clk;

    lab_ass_2 #(.TRUTH_TABLE(16'hF222), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(inValid), .a(a), .b(b), .c(c), .d(d),
`ifdef LAB_ASS_2_TT_PROG_EN
        .tt_we(ttWe), .tt_wdata(ttWdata),
`endif
        .f_comb(fComb), .f(f), .f_valid(fValid), .true_cnt(trueCnt)
    );

    lab_ass_2 #(.TRUTH_TABLE(16'hF222), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid), .a(a), .b(b), .c(c), .d(d),
`ifdef LAB_ASS_2_TT_PROG_EN
        .tt_we(ttWe), .tt_wdata(ttWdata),
`endif
        .f_comb(fComb2), .f(f2), .f_valid(fValid2), .true_cnt(trueCnt2)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mF    = 1'b0;
        mCnt  = '0;
        mCnt2 = '0;
        tbl   = SPEC_TT;
        sb.delete();
    endtask

    // Drive one cycle, check f_comb combinationally, push the expected registered state.
    task automatic applyStimulus(input logic v, input logic [3:0] idx,
                                 input logic we, input logic [15:0] wd);
        inValid      = v;
        {a, b, c, d} = idx;
`ifdef LAB_ASS_2_TT_PROG_EN
        ttWe    = we;
        ttWdata = wd;
`endif
        #1;
        check("f_comb", fComb, tbl[idx]);
        check("f_comb_w2", fComb2, tbl[idx]);
        if (v) begin
            mF = tbl[idx];
            if (mF && mCnt != 8'hFF) mCnt++;
            if (mF && mCnt2 != 2'd3) mCnt2++;
        end
        sb.push_back('{f: mF, fv: v, cnt: mCnt, cnt2: mCnt2});
`ifdef LAB_ASS_2_TT_PROG_EN
        if (we) tbl = wd;
`endif
        @(posedge clk);
        #1;
`ifdef LAB_ASS_2_TT_PROG_EN
        ttWe = 1'b0;
`endif
    endtask

    task automatic checkOutput();
        exp_t e;
        check("sb_nonempty", 8'(sb.size() != 0), 8'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("f", f, e.f);
            check("f_valid", fValid, e.fv);
            check("true_cnt", trueCnt, e.cnt);
            check("f_w2", f2, e.f);
            check("f_valid_w2", fValid2, e.fv);
            check("true_cnt_w2", trueCnt2, e.cnt2);
        end
    endtask

    task automatic asyncReset();
        #2 rst = 1'b1;
        #1;
        check("rst_f", f, 1'b0);
        check("rst_f_valid", fValid, 1'b0);
        check("rst_cnt", trueCnt, 8'd0);
        check("rst_cnt_w2", trueCnt2, 2'd0);
        resetModel();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] spotIdx [5] = '{4'd0, 4'd1, 4'd6, 4'd12, 4'd15};
        logic       spotExp [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst     = 1'b1;
        inValid = 1'b0;
        {a, b, c, d} = 4'd0;
`ifdef LAB_ASS_2_TT_PROG_EN
        ttWe    = 1'b0;
        ttWdata = '0;
`endif
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        check("reset_f", f, 1'b0);
        check("reset_f_valid", fValid, 1'b0);
        check("reset_cnt", trueCnt, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'(i), 1'b0, 16'h0);
            checkOutput();
        end
        check("sweep_final_cnt", trueCnt, 8'd7);
        check("sweep_final_cnt_w2", trueCnt2, 2'd3);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, spotIdx[i], 1'b0, 16'h0);
            checkOutput();
            check("spot_f", f, spotExp[i]);
        end

        applyStimulus(1'b1, 4'd13, 1'b0, 16'h0);
        checkOutput();
        applyStimulus(1'b0, 4'd2, 1'b0, 16'h0);
        checkOutput();
        check("hold_f", f, 1'b1);
        check("hold_f_valid", fValid, 1'b0);
        check("hold_cnt", trueCnt, 8'd11);
        applyStimulus(1'b0, 4'd5, 1'b0, 16'h0);
        checkOutput();

        applyStimulus(1'b1, 4'd3, 1'b0, 16'h0);
        checkOutput();
        applyStimulus(1'b1, 4'd4, 1'b0, 16'h0);
        checkOutput();
        asyncReset();
        applyStimulus(1'b1, 4'd9, 1'b0, 16'h0);
        checkOutput();
        check("resume_f", f, 1'b1);
        check("resume_f_valid", fValid, 1'b1);

        asyncReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'd15, 1'b0, 16'h0);
            checkOutput();
            check("sat_cnt_w2", trueCnt2, satSeq[i]);
        end

`ifdef LAB_ASS_2_TT_PROG_EN
        asyncReset();
        applyStimulus(1'b1, 4'd15, 1'b1, 16'h8000);
        checkOutput();
        check("prog_old_table_f", f, 1'b1);
        applyStimulus(1'b1, 4'd15, 1'b0, 16'h0);
        check("prog_new_idx15", fComb, 1'b1);
        checkOutput();
        applyStimulus(1'b1, 4'd12, 1'b0, 16'h0);
        check("prog_new_idx12", fComb, 1'b0);
        checkOutput();
        check("prog_new_f12", f, 1'b0);
        applyStimulus(1'b1, 4'd12, 1'b1, 16'h0000);
        checkOutput();
        asyncReset();
        applyStimulus(1'b0, 4'd12, 1'b0, 16'h0);
        check("prog_reset_restore", fComb, 1'b1);
        checkOutput();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lab_ass_2.md
Name: lab_ass_2

Overview:
- Clocked 4-input Boolean function evaluator; inputs a,b,c,d are the index into a 16-entry truth table.
- Provides a combinational result f_comb and a registered, valid-qualified result f.
- Counts true results in a saturating counter.
- Leaf block used wherever a small fixed or programmable logic function of four control bits is needed.

Parameters:
- TRUTH_TABLE, 16'hF222, bit i is the output for index i = {a,b,c,d} (a is MSB). Default implements F = (A&B) | (~C&D).
- CNT_W, 8, width of the true-result counter; must be at least 1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  a,b,c,d sampled this cycle
- a  input  1  index bit 3 (MSB)
- b  input  1  index bit 2
- c  input  1  index bit 1
- d  input  1  index bit 0 (LSB)
- f_comb  output  1  combinational table[{a,b,c,d}], independent of in_valid and reset
- f  output  1  registered result
- f_valid  output  1  f holds a freshly evaluated result
- true_cnt  output  CNT_W  saturating count of valid evaluations with result 1

Behaviour:
- idx = {a,b,c,d}; f_comb = active_table[idx], purely combinational, zero latency.
- Reset (async assert, deassert honoured at next edge): f=0, f_valid=0, true_cnt=0; active table set to TRUTH_TABLE.
- Each rising edge with in_valid=1: f <= f_comb, f_valid <= 1. Latency is 1 cycle.
- Each edge with in_valid=0: f holds its last value, f_valid <= 0.
- Counter: on an edge with in_valid=1 and f_comb=1, true_cnt increments by 1.
- Counter saturates at 2^CNT_W-1 and never wraps. It clears only on reset.
- If reset asserts mid-stream, all outputs clear immediately. The first result after release appears one edge after the first in_valid.
- No backpressure: a new evaluation is accepted every cycle.
- X or Z on a,b,c,d is not supported. Inputs are required to be driven 0/1 whenever in_valid=1.

Optional Feature:
- Macro LAB_ASS_2_TT_PROG_EN.
- When defined, two extra ports are added:
  - tt_we  input  1
  - tt_wdata  input  16
- With the macro: the active table is a 16-bit register, reset to TRUTH_TABLE.
  - On an edge with tt_we=1, the table loads tt_wdata.
  - f_comb uses the new table from the following cycle.
  - If tt_we and in_valid occur in the same cycle, the evaluation uses the old table.
- Without the macro: the active table is the constant TRUTH_TABLE and the extra ports do not exist.

Decomposition:
- Shared package lab_ass_2_pkg holds:
  - the DEFAULT_TT constant (16'hF222)
  - the index typedef (logic [3:0])
  - the table typedef (logic [15:0])
- One natural sub-module, lab_ass_2_sat_cnt: a generic saturating up-counter (parameter width, inc input, async reset).
- Table lookup and output register stay in the top module.

Test Plan:
- Exhaustive sweep, one index per cycle, in_valid=1, idx 0..15 → f_comb follows 0100_0100_0100_1111 in index order. f matches one cycle later with f_valid=1. Final true_cnt=7.
- Spot checks → idx 0 gives 0; idx 1 gives 1; idx 6 gives 0; idx 12 gives 1; idx 15 gives 1.
- in_valid=0 after idx 13 evaluated → f stays 1, f_valid=0, true_cnt unchanged, f_comb still tracks inputs.
- CNT_W=2, idx 15 held valid for 6 cycles → true_cnt reads 1,2,3,3,3,3.
- Assert rst asynchronously mid-sweep (between edges) → f, f_valid, true_cnt are 0 immediately. Resuming at idx 9 gives f=1 one cycle after the first valid.
- With LAB_ASS_2_TT_PROG_EN: write tt_wdata=16'h8000 while idx=15 is valid → that cycle f=1 (old table). Next cycle f_comb=1 for idx 15 and 0 for idx 12. A reset restores 16'hF222.
